// File: rtl/allpass_pkg.sv
// Shared types and constants for the allpass filter and its coefficient controller.
package allpass_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 7;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        FLUSH
    } state_t;

    // LSB position of coefficient k on the packed coefficient bus.
    function automatic int coef_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/allpass_coef_bank.sv
// Coefficient register bank: single-entry write port, whole-bank load, packed output.
module allpass_coef_bank
    import allpass_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NC    = DEF_N - 1,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  load,
    input  logic [WIDTH*NC-1:0]   load_data,
    output logic [WIDTH*NC-1:0]   q
);

    // Bulk load takes priority over a single-entry write; the top never issues both.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (wr_en && wr_addr == AW'(k))
                    q[coef_lsb(k, WIDTH) +: WIDTH] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/allpass_coef_ctrl.sv
// Double-buffered coefficient controller: host writes land in a shadow bank and
// are committed atomically to the active bank on a sample strobe, optionally
// flushing the filter state.
module allpass_coef_ctrl
    import allpass_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int N            = DEF_N,
    parameter int AW           = 3,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   commit,
    input  logic                   commit_flush,
    input  logic                   sample_stb,
    output logic [WIDTH*(N-1)-1:0] c_out,
    output logic                   filt_rst,
    output logic                   pending,
    output logic                   err_addr,
    output logic                   err_commit
);

    localparam int NC = N - 1;
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_t                state, state_nxt;
    logic                  rst_q;      // high for the cycles that follow a reset edge
    logic                  flush_cap;
    logic [CW-1:0]         cnt;
    logic [WIDTH*NC-1:0]   shadow;

    logic wr_ok, addr_ok, commit_ok, load;

    assign wr_ready  = (state == IDLE) && !rst_q;
    assign filt_rst  = rst_q || (state == FLUSH);
    assign pending   = (state == PENDING);
    assign wr_ok     = wr_valid && wr_ready;
    assign addr_ok   = wr_addr <= AW'(NC - 1);
    assign commit_ok = commit && wr_ready;
    assign load      = (state == PENDING) && sample_stb;

    allpass_coef_bank #(.WIDTH(WIDTH), .NC(NC), .AW(AW)) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_ok && addr_ok),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .load      (1'b0),
        .load_data ('0),
        .q         (shadow)
    );

    allpass_coef_bank #(.WIDTH(WIDTH), .NC(NC), .AW(AW)) u_active (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_addr   ('0),
        .wr_data   ('0),
        .load      (load),
        .load_data (shadow),
        .q         (c_out)
    );

    // Next-state: a non-flushing swap goes straight back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit_ok) state_nxt = PENDING;
            PENDING: if (sample_stb) state_nxt = flush_cap ? FLUSH : IDLE;
            FLUSH:   if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, captured flush flag, flush countdown and registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rst_q      <= 1'b1;
            flush_cap  <= 1'b0;
            cnt        <= '0;
            err_addr   <= 1'b0;
            err_commit <= 1'b0;
        end else begin
            state      <= state_nxt;
            rst_q      <= 1'b0;
            if (commit_ok)
                flush_cap <= commit_flush;
            if (load && flush_cap)
                cnt <= CW'(FLUSH_CYCLES - 1);
            else if (state == FLUSH && cnt != '0)
                cnt <= cnt - 1'b1;
            err_addr   <= wr_ok && !addr_ok;
            err_commit <= commit && !commit_ok;
        end
    end

endmodule

// File: tb/tb_allpass_coef_ctrl.sv
// Directed bench for allpass_coef_ctrl with hand-computed expected values.
module tb_allpass_coef_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit, commit_flush, sample_stb;
    logic [95:0] c_out;
    logic        filt_rst, pending, err_addr, err_commit;

    int total = 0;
    int bad   = 0;

    localparam logic [95:0] SET_A = 96'h0100_0200_0400_F800_0800_1000;
    localparam logic [95:0] SET_B = 96'h0100_0200_0400_3000_0800_1000;
    localparam logic [95:0] SET_C = 96'h0100_0200_0400_3000_0ABC_5555;

    always #5 clk = ~clk;

    allpass_coef_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .commit_flush(commit_flush), .sample_stb(sample_stb),
        .c_out(c_out), .filt_rst(filt_rst), .pending(pending),
        .err_addr(err_addr), .err_commit(err_commit)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 0; wr_addr = 0; wr_data = 0;
        commit = 0; commit_flush = 0; sample_stb = 0;

        // reset release
        repeat (3) step();
        chk("rst_cout", c_out, 0);
        chk("rst_filt", filt_rst, 1);
        chk("rst_ready", wr_ready, 0);
        chk("rst_pend", pending, 0);
        rst = 1'b0;
        step();
        chk("rel_filt", filt_rst, 0);
        chk("rel_ready", wr_ready, 1);
        chk("rel_pend", pending, 0);

        // basic commit
        wr(0, 16'h1000); wr(1, 16'h0800); wr(2, 16'hF800);
        wr(3, 16'h0400); wr(4, 16'h0200); wr(5, 16'h0100);
        commit = 1'b1; step(); commit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("a_pend", pending, 1);
            chk("a_ready", wr_ready, 0);
            chk("a_filt", filt_rst, 0);
            if (i < 4) step();
        end
        sample_stb = 1'b1;
        chk("a_cout_pre", c_out, 0);
        step(); sample_stb = 1'b0;
        chk("a_cout", c_out, SET_A);
        chk("a_filt_post", filt_rst, 0);
        chk("a_pend_post", pending, 0);
        chk("a_ready_post", wr_ready, 1);

        // flushing commit
        wr(2, 16'h3000);
        commit = 1'b1; commit_flush = 1'b1; step(); commit = 1'b0; commit_flush = 1'b0;
        sample_stb = 1'b1;
        chk("f_cout_pre", c_out, SET_A);
        chk("f_filt_pre", filt_rst, 0);
        step(); sample_stb = 1'b0;
        chk("f_cout", c_out, SET_B);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("f_filt%0d", i), filt_rst, 1);
            chk($sformatf("f_ready%0d", i), wr_ready, 0);
            step();
        end
        chk("f_filt_end", filt_rst, 0);
        chk("f_ready_end", wr_ready, 1);

        // bad address: dropped, pulse next cycle, shadow intact
        wr(6, 16'h7FFF);
        chk("ba_err", err_addr, 1);
        step();
        chk("ba_err_clr", err_addr, 0);

        // commit, second commit while pending, blocked write
        commit = 1'b1; step();
        chk("dc_err0", err_commit, 0);
        step(); commit = 1'b0;
        chk("dc_err1", err_commit, 1);
        wr_valid = 1'b1; wr_addr = 0; wr_data = 16'h5555;
        chk("blk_ready", wr_ready, 0);
        step(); wr_valid = 1'b0;
        chk("dc_err_clr", err_commit, 0);
        sample_stb = 1'b1; step(); sample_stb = 1'b0;
        chk("blk_cout", c_out, SET_B);
        chk("blk_pend", pending, 0);
        chk("blk_filt", filt_rst, 0);
        step();
        chk("single_xfer_pend", pending, 0);

        // retry write, then commit with same-cycle write and strobe
        wr(0, 16'h5555);
        wr_valid = 1'b1; wr_addr = 1; wr_data = 16'h0ABC;
        commit = 1'b1; sample_stb = 1'b1;
        step();
        wr_valid = 1'b0; commit = 1'b0; sample_stb = 1'b0;
        chk("ov_pend", pending, 1);
        chk("ov_cout_hold", c_out, SET_B);
        step();
        chk("ov_cout_hold2", c_out, SET_B);
        sample_stb = 1'b1; step(); sample_stb = 1'b0;
        chk("ov_cout", c_out, SET_C);

        // reset during flush
        wr(5, 16'h0001);
        commit = 1'b1; commit_flush = 1'b1; step(); commit = 1'b0; commit_flush = 1'b0;
        sample_stb = 1'b1; step(); sample_stb = 1'b0;
        chk("rf_cout", c_out, 96'h0001_0200_0400_3000_0ABC_5555);
        step(); step();
        chk("rf_filt3", filt_rst, 1);
        rst = 1'b1; step();
        chk("rf_cout0", c_out, 0);
        chk("rf_filt_rst", filt_rst, 1);
        rst = 1'b0; step();
        chk("rf_filt_rel", filt_rst, 0);
        chk("rf_ready", wr_ready, 1);
        chk("rf_pend", pending, 0);
        chk("rf_cout_rel", c_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/allpass_coef_ctrl.md
Name: allpass_coef_ctrl

Overview:
Double-buffered coefficient controller for the fixed-point allpass filter. It takes coefficient writes from a config/host port into a shadow bank and commits them atomically to the active packed coefficient bus on a sample-frame boundary. It can optionally flush the filter's delay lines through a generated filter reset. It sits between the register/config interface and the filter's c and rst inputs.

Parameters:
WIDTH, 16, coefficient word width; matches the filter WIDTH
N, 7, filter order parameter; the coefficient count is N-1
AW, 3, write address width; must satisfy 2**AW >= N-1
FLUSH_CYCLES, 8, cycles filt_rst is held on a flushing commit; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  reset
wr_valid  in  1  coefficient write request
wr_ready  out  1  controller can accept a write this cycle
wr_addr  in  AW  coefficient index, 0..N-2
wr_data  in  WIDTH  signed coefficient value, Q(FIXEDPOINT) format as used by the filter
commit  in  1  single-cycle pulse: request shadow-to-active transfer
commit_flush  in  1  sampled with commit; 1 = also flush the filter state
sample_stb  in  1  frame/sample boundary strobe; commits take effect only here
c_out  out  WIDTH*(N-1)  packed active coefficients; entry k occupies bits [WIDTH*(k+1)-1 : WIDTH*k]
filt_rst  out  1  synchronous active-high reset to the filter
pending  out  1  a commit is waiting for sample_stb
err_addr  out  1  one-cycle pulse: write dropped because wr_addr > N-2
err_commit  out  1  one-cycle pulse: commit dropped because one is already pending or flushing

Behaviour:
- Reset: rst is synchronous, active-high; clk is the only clock. On rst, shadow and active banks clear to 0, so c_out = 0 and the filter acts as a pure delay. State goes to IDLE. filt_rst = 1, wr_ready = 0, pending = 0, err_* = 0. The first cycle after rst deasserts has filt_rst = 0 and wr_ready = 1.
- States:
  - IDLE: wr_ready = 1. Accepted commit → PENDING.
  - PENDING: wr_ready = 0, pending = 1. sample_stb → SWAP (captured flush = 0) or FLUSH (captured flush = 1).
  - FLUSH: wr_ready = 0, filt_rst = 1 for FLUSH_CYCLES cycles, then → IDLE.
  - SWAP is a transfer action, not a dwell state: a non-flushing swap returns to IDLE in the same transition.
- Writes: a write is accepted when wr_valid && wr_ready. If wr_addr <= N-2, shadow[wr_addr] <= wr_data. Otherwise the write is dropped and err_addr pulses on the next cycle. Writes never touch the active bank directly.
- Commit: accepted only in IDLE. commit_flush is captured in the same cycle. If a write is accepted in the same cycle as the commit, the write is included in the committed set.
- Commit outside IDLE is ignored, and err_commit pulses on the next cycle.
- Transfer: on the sample_stb cycle in PENDING, active <= shadow; c_out shows the new set on the next cycle (latency 1 from the strobe).
  - If a sample_stb and a commit arrive in the same cycle while IDLE, the strobe is not used. The transfer waits for the next sample_stb.
  - On a flushing commit, filt_rst asserts on the same cycle c_out changes and is held for exactly FLUSH_CYCLES cycles. wr_ready returns to 1 on the cycle filt_rst falls.
- sample_stb is ignored in IDLE and FLUSH.
- Shadow contents persist after a commit, so a partial update needs only the changed indices.
- rst asserted mid-PENDING or mid-FLUSH aborts immediately. Both banks clear and the state returns to IDLE.
- c_out is register-driven with no combinational path from any input, so the filter's combinational multiply chain sees stable coefficients.

Decomposition:
- Shared package allpass_pkg holds:
  - state enum {IDLE, PENDING, FLUSH};
  - the helper function for the packed-bus slice index of coefficient k;
  - default WIDTH/N constants, shared with the filter wrapper.
- One natural sub-module, allpass_coef_bank: an N-1 entry WIDTH register array with write port, bulk-load port and packed output. Instantiate it twice, once as shadow and once as active.
- FSM, flush counter and error pulses stay in the top level.

Test Plan:
- Reset release: hold rst 3 cycles, then drop it → c_out = 0 and filt_rst = 1 during rst; cycle after release filt_rst = 0, wr_ready = 1, pending = 0.
- Basic commit: write addr0..5 = 0x1000, 0x0800, 0xF800, 0x0400, 0x0200, 0x0100; commit (flush = 0); sample_stb 5 cycles later → pending high for those 5 cycles; c_out = {0x0100, 0x0200, 0x0400, 0xF800, 0x0800, 0x1000} exactly one cycle after the strobe; filt_rst never asserts.
- Flush commit: write addr2 = 0x3000, commit with commit_flush = 1, sample_stb → c_out slice 2 = 0x3000 and filt_rst high for exactly 8 cycles, both starting the cycle after the strobe; wr_ready = 0 throughout; filter dout = 0 during the flush.
- Bad address and blocked writes: write addr 6 = 0x7FFF → err_addr pulse, shadow unchanged. Write while PENDING → wr_ready = 0 and not accepted; the value appears only if retried after returning to IDLE.
- Overlapping events: commit in the same cycle as a write to addr1 = 0x0ABC → committed set contains 0x0ABC. A second commit while PENDING → err_commit pulse and a single transfer. A sample_stb in the same cycle as the commit → no transfer until the next strobe.
- Reset mid-flush: assert rst on FLUSH cycle 3 → c_out = 0 the next cycle; after release state is IDLE and filt_rst drops the cycle after rst deasserts.
